hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core, replacing the purely combinational hazard logic. Covers:
- operand forwarding and load-use stall;
- branch flush;
- multi-cycle MDU (mul/div) occupancy in Execute, via an internal latency counter FSM;
- data-memory wait states in Memory, via a ready handshake.

It drives all stage stall/flush enables and both E-stage forwarding selects.

Parameters:
REG_AW, 5, register address width
MDU_LAT, 4, total cycles an MDU instruction occupies Execute (>=1)
CNT_W, 32, perf counter width (only with HAZARD_PERF_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
Rs1D, Rs2D  in  REG_AW  Decode source regs
Rs1E, Rs2E, RdE  in  REG_AW  Execute source/dest regs
ResultSrcE  in  2  bit0=1 marks load in Execute
MduStartE  in  1  instruction in Execute is an MDU op
Hazard_PCsrc  in  1  taken branch/jump resolved in Execute
RdM, RdW  in  REG_AW  Memory/Writeback dest regs
RegWriteM, RegWriteW  in  1  dest write enables
MemReqM  in  1  Memory stage accesses data memory
MemReadyM  in  1  data memory completes this cycle
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushM, FlushW  out  1  bubble into stage register
ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM
MduLastE  out  1  final MDU cycle in Execute; datapath captures MDU result
PCsrcEn  out  1  branch redirect permitted (Hazard_PCsrc & ~StallE)

Behaviour:
- Reset (async, rst high): state IDLE, cnt=0; all Stall*/Flush*/MduLastE/PCsrcEn=0, Forward*E=00 while rst high.
- Forwarding (comb): for each operand, Rs==RdM & RegWriteM & Rs!=0 -> 10; else Rs==RdW & RegWriteW & Rs!=0 -> 01; else 00. M takes priority over W.
- memStall = MemReqM & ~MemReadyM.
- MDU FSM, states IDLE and BUSY; cnt is REG of width clog2(MDU_LAT):
  - IDLE & MduStartE & MDU_LAT>1: mduStall=1, cnt<=MDU_LAT-2, ->BUSY.
  - IDLE & MduStartE & MDU_LAT==1: MduLastE=1, no stall, stay IDLE.
  - BUSY & cnt!=0: mduStall=1, cnt decrements every cycle (unit runs even during memStall).
  - BUSY & cnt==0: MduLastE=1, mduStall=0. ->IDLE unless memStall, which holds BUSY with cnt=0.
  - MduStartE is ignored in BUSY.
  - Net effect: the MDU instruction spends exactly MDU_LAT cycles in Execute absent memStall.
- Load-use (comb): lwStall = ResultSrcE[0] & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- StallE = memStall | mduStall; lwEff = lwStall & ~StallE.
- Output equations:
  - StallF = StallD = StallE | lwEff.
  - StallM = memStall; FlushW = memStall.
  - FlushM = mduStall & ~memStall.
  - FlushE = (lwEff | Hazard_PCsrc) & ~StallE; FlushD = Hazard_PCsrc & ~StallE; PCsrcEn = Hazard_PCsrc & ~StallE.
- Priority: memStall > mduStall > lwStall > branch flush. A frozen Execute never flushes or redirects; its branch re-asserts once released.
- Reset mid-MDU: state returns to IDLE immediately; no MduLastE is generated.

Optional Feature:
HAZARD_PERF_EN:
- Defined: four CNT_W counters, cleared on rst, saturating at all-ones, each incrementing once per cycle of its condition:
  - lw_stall_cnt: lwEff
  - mdu_stall_cnt: mduStall & ~memStall
  - mem_stall_cnt: memStall
  - flush_cnt: FlushD
- Defined: output ports of the same names are added.
- Undefined: no counters and no extra ports.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - hz_state_t enum: IDLE, BUSY
- Sub-module fwd_sel (Rs, RdM, RdW, RegWriteM, RegWriteW -> fwd_sel_t), instantiated twice for A and B.

Test Plan:
- Forward priority: Rs1E=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. Rs1E=0 with all matches -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
- MDU with MDU_LAT=4: MduStartE held -> mduStall for 3 cycles with FlushM=1, MduLastE=1 on cycle 4, then IDLE. MDU_LAT=1 -> no stall, MduLastE on the start cycle.
- Memory wait: MemReqM=1, MemReadyM=0 for 2 cycles with Hazard_PCsrc=1 -> StallF..StallM=1, FlushW=1, FlushD=FlushE=PCsrcEn=0. On ready, FlushD=FlushE=1.
- Overlap: MDU busy with cnt reaching 0 during memStall -> stays BUSY, MduLastE repeats until memStall clears, then IDLE.
- Reset: assert rst mid-BUSY (cnt=1) -> all outputs 0 asynchronously. After release, MduStartE=0 gives no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

    function automatic int cnt_width(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [1:0]        ResultSrcE;
    logic              MduStartE;
    logic              Hazard_PCsrc;
    logic [REG_AW-1:0] RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic              MemReqM, MemReadyM;

    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushM, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MduLastE;
    logic              PCsrcEn;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MduStartE, Hazard_PCsrc,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MduLastE, PCsrcEn
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MduStartE, Hazard_PCsrc,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MduLastE, PCsrcEn
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - one Execute operand forwarding select
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);
    // x0 is hardwired, so it is never forwarded; Memory is younger and wins.
    always_comb begin
        sel = FWD_REG;
        if (rs != '0) begin
            if (reg_write_m && rs == rd_m)
                sel = FWD_MEM;
            else if (reg_write_w && rs == rd_w)
                sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with MDU occupancy and memory waits
// Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] mdu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam int              CW       = cnt_width(MDU_LAT);
    localparam bit              MULTI    = (MDU_LAT > 1);
    localparam logic [CW-1:0]   CNT_INIT = MULTI ? CW'(MDU_LAT - 2) : '0;

    hz_state_t     state;
    logic [CW-1:0] cnt;

    fwd_sel_t fwd_a, fwd_b;
    logic     mem_stall, mdu_stall, mdu_last, lw_stall, stall_e, lw_eff;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(hz.Rs1E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .sel(fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(hz.Rs2E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .sel(fwd_b)
    );

    assign mem_stall = hz.MemReqM & ~hz.MemReadyM;

    // The unit keeps counting through memory waits; only the exit is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.MduStartE && MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (!mem_stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mdu_stall = 1'b0;
        mdu_last  = 1'b0;
        if (state == IDLE) begin
            if (hz.MduStartE) begin
                mdu_stall = MULTI;
                mdu_last  = !MULTI;
            end
        end else if (cnt != '0) begin
            mdu_stall = 1'b1;
        end else begin
            mdu_last = 1'b1;
        end
    end

    assign lw_stall = hz.ResultSrcE[0] && (hz.RdE != '0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign stall_e  = mem_stall | mdu_stall;
    assign lw_eff   = lw_stall & ~stall_e;

    // Outputs are forced quiet for the whole time reset is held.
    assign hz.StallF    = ~rst & (stall_e | lw_eff);
    assign hz.StallD    = ~rst & (stall_e | lw_eff);
    assign hz.StallE    = ~rst & stall_e;
    assign hz.StallM    = ~rst & mem_stall;
    assign hz.FlushW    = ~rst & mem_stall;
    assign hz.FlushM    = ~rst & mdu_stall & ~mem_stall;
    assign hz.FlushE    = ~rst & (lw_eff | hz.Hazard_PCsrc) & ~stall_e;
    assign hz.FlushD    = ~rst & hz.Hazard_PCsrc & ~stall_e;
    assign hz.PCsrcEn   = ~rst & hz.Hazard_PCsrc & ~stall_e;
    assign hz.MduLastE  = ~rst & mdu_last;
    assign hz.ForwardAE = rst ? FWD_REG : fwd_a;
    assign hz.ForwardBE = rst ? FWD_REG : fwd_b;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lw_stall_cnt  <= '0;
            mdu_stall_cnt <= '0;
            mem_stall_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (lw_eff && !(&lw_stall_cnt))
                lw_stall_cnt <= lw_stall_cnt + 1'b1;
            if (mdu_stall && !mem_stall && !(&mdu_stall_cnt))
                mdu_stall_cnt <= mdu_stall_cnt + 1'b1;
            if (mem_stall && !(&mem_stall_cnt))
                mem_stall_cnt <= mem_stall_cnt + 1'b1;
            if (hz.Hazard_PCsrc && !stall_e && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       start, pcsrc, rwm, rww, req, rdy;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [13:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hz0 ();
    hazard_ctrl_if #(.REG_AW(5)) hz1 ();

    hazard_ctrl #(.REG_AW(5), .MDU_LAT(4), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .hz(hz0));
    hazard_ctrl #(.REG_AW(5), .MDU_LAT(1), .CNT_W(32)) u_dut1 (.clk(clk), .rst(rst), .hz(hz1));

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MduLastE,PCsrcEn,ForwardAE,ForwardBE}
    logic [13:0] out0, out1;
    assign out0 = {hz0.StallF, hz0.StallD, hz0.StallE, hz0.StallM, hz0.FlushD, hz0.FlushE,
                   hz0.FlushM, hz0.FlushW, hz0.MduLastE, hz0.PCsrcEn, hz0.ForwardAE, hz0.ForwardBE};
    assign out1 = {hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM, hz1.FlushD, hz1.FlushE,
                   hz1.FlushM, hz1.FlushW, hz1.MduLastE, hz1.PCsrcEn, hz1.ForwardAE, hz1.ForwardBE};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: age of the MDU op in Execute, counting up from 1.
    int lat  [2] = '{4, 1};
    bit busy [2] = '{0, 0};
    int age  [2] = '{0, 0};

    function automatic in_t mk(input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rsrc,
                               input bit start, pcsrc, rwm, rww, req, rdy);
        in_t r;
        r.rs1d = 5'(rs1d); r.rs2d = 5'(rs2d); r.rs1e = 5'(rs1e); r.rs2e = 5'(rs2e);
        r.rde = 5'(rde); r.rdm = 5'(rdm); r.rdw = 5'(rdw); r.rsrc = 2'(rsrc);
        r.start = start; r.pcsrc = pcsrc; r.rwm = rwm; r.rww = rww; r.req = req; r.rdy = rdy;
        return r;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t i);
        if (rs != 0 && i.rwm && rs == i.rdm) return 2'b10;
        if (rs != 0 && i.rww && rs == i.rdw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] ref_out(input int k, input in_t i);
        bit active, mdu, last, mem, se, lw, lwe, fl;
        int a;
        active = busy[k] || i.start;
        a      = busy[k] ? age[k] : 1;
        mdu    = active && (a < lat[k]);
        last   = active && (a >= lat[k]);
        mem    = i.req && !i.rdy;
        se     = mem || mdu;
        lw     = i.rsrc[0] && i.rde != 0 && (i.rs1d == i.rde || i.rs2d == i.rde);
        lwe    = lw && !se;
        fl     = i.pcsrc && !se;
        return {se | lwe, se | lwe, se, mem, fl, (lwe | i.pcsrc) & !se,
                mdu & !mem, mem, last, fl, ref_fwd(i.rs1e, i), ref_fwd(i.rs2e, i)};
    endfunction

    task automatic model_step(input in_t i);
        for (int k = 0; k < 2; k++) begin
            bit active;
            int a;
            active = busy[k] || i.start;
            a      = busy[k] ? age[k] : 1;
            if (active && a < lat[k]) begin
                busy[k] = 1; age[k] = a + 1;
            end else if (!(busy[k] && i.req && !i.rdy)) begin
                busy[k] = 0;
            end
        end
    endtask

    task automatic drive(input in_t i);
        hz0.Rs1D = i.rs1d; hz0.Rs2D = i.rs2d; hz0.Rs1E = i.rs1e; hz0.Rs2E = i.rs2e;
        hz0.RdE = i.rde; hz0.RdM = i.rdm; hz0.RdW = i.rdw; hz0.ResultSrcE = i.rsrc;
        hz0.MduStartE = i.start; hz0.Hazard_PCsrc = i.pcsrc; hz0.RegWriteM = i.rwm;
        hz0.RegWriteW = i.rww; hz0.MemReqM = i.req; hz0.MemReadyM = i.rdy;
        hz1.Rs1D = i.rs1d; hz1.Rs2D = i.rs2d; hz1.Rs1E = i.rs1e; hz1.Rs2E = i.rs2e;
        hz1.RdE = i.rde; hz1.RdM = i.rdm; hz1.RdW = i.rdw; hz1.ResultSrcE = i.rsrc;
        hz1.MduStartE = i.start; hz1.Hazard_PCsrc = i.pcsrc; hz1.RegWriteM = i.rwm;
        hz1.RegWriteW = i.rww; hz1.MemReqM = i.req; hz1.MemReadyM = i.rdy;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One pipeline cycle: drive after the edge, compare mid-cycle, advance the model.
    task automatic step(input in_t i, input string name, input logic [13:0] exp0,
                        input bit chk0, input logic [13:0] exp1, input bit chk1);
        @(posedge clk);
        #1;
        drive(i);
        @(negedge clk);
        if (chk0) check({name, "/lat4"}, out0, exp0);
        if (chk1) check({name, "/lat1"}, out1, exp1);
        model_step(i);
    endtask

    vec_t tbl[$];

    initial begin
        in_t z, i;
        z = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0);

        // Reset holds every output quiet regardless of inputs.
        i = mk(3,3,3,3,3,3,3,1, 1,1,1,1,1,0);
        drive(i);
        #2;
        check("reset_state", out0, 14'b0);
        @(negedge clk);
        drive(z);
        rst = 1'b0;

        tbl.push_back('{"fwd_mem_prio", mk(0,0,5,0,0,5,5,0, 0,0,1,1,0,0), 14'b0000000000_10_00});
        tbl.push_back('{"fwd_wb",       mk(0,0,5,0,0,5,5,0, 0,0,0,1,0,0), 14'b0000000000_01_00});
        tbl.push_back('{"fwd_x0",       mk(0,0,0,0,0,0,0,0, 0,0,1,1,0,0), 14'b0000000000_00_00});
        tbl.push_back('{"fwd_a_b",      mk(0,0,4,3,0,4,3,0, 0,0,1,1,0,0), 14'b0000000000_10_01});
        tbl.push_back('{"load_use",     mk(0,7,0,0,7,0,0,1, 0,0,0,0,0,0), 14'b1100010000_00_00});
        tbl.push_back('{"load_use_x0",  mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0), 14'b0000000000_00_00});
        tbl.push_back('{"not_load",     mk(7,0,0,0,7,0,0,2, 0,0,0,0,0,0), 14'b0000000000_00_00});
        tbl.push_back('{"branch",       mk(0,0,0,0,0,0,0,0, 0,1,0,0,0,0), 14'b0000110001_00_00});
        tbl.push_back('{"mem_wait1",    mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,0), 14'b1111000100_00_00});
        tbl.push_back('{"mem_wait2",    mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,0), 14'b1111000100_00_00});
        tbl.push_back('{"mem_ready",    mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,1), 14'b0000110001_00_00});
        tbl.push_back('{"mem_over_lw",  mk(7,0,0,0,7,0,0,1, 0,0,0,0,1,0), 14'b1111000100_00_00});
        tbl.push_back('{"lw_and_br",    mk(7,0,0,0,7,0,0,1, 0,1,0,0,0,0), 14'b1100110001_00_00});
        foreach (tbl[n]) step(tbl[n].in, tbl[n].name, tbl[n].exp, 1, 14'b0, 0);

        // MDU held in Execute: three stall cycles then the result cycle.
        i = mk(0,0,0,0,0,0,0,0, 1,0,0,0,0,0);
        for (int c = 1; c <= 4; c++)
            step(i, $sformatf("mdu_c%0d", c),
                 (c < 4) ? 14'b1110001000_00_00 : 14'b0000000010_00_00, 1,
                 14'b0000000010_00_00, 1);
        step(z, "mdu_idle", 14'b0, 1, 14'b0, 1);

        // Count expires during a memory wait: result cycle repeats until released.
        for (int c = 1; c <= 3; c++) step(i, $sformatf("ovl_c%0d", c), 14'b1110001000_00_00, 1, 14'b0, 0);
        i = mk(0,0,0,0,0,0,0,0, 1,0,0,0,1,0);
        step(i, "ovl_mem1", 14'b1111000110_00_00, 1, 14'b0, 0);
        step(i, "ovl_mem2", 14'b1111000110_00_00, 1, 14'b0, 0);
        i = mk(0,0,0,0,0,0,0,0, 1,0,0,0,1,1);
        step(i, "ovl_release", 14'b0000000010_00_00, 1, 14'b0, 0);
        step(z, "ovl_idle", 14'b0, 1, 14'b0, 0);

        // Reset while BUSY with one count left.
        i = mk(0,0,0,0,0,0,0,0, 1,0,0,0,0,0);
        step(i, "rst_pre1", 14'b1110001000_00_00, 1, 14'b0, 0);
        step(i, "rst_pre2", 14'b1110001000_00_00, 1, 14'b0, 0);
        @(posedge clk);
        #1;
        drive(mk(3,3,3,3,3,3,3,1, 1,1,1,1,1,0));
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", out0, 14'b0);
        busy = '{0, 0};
        @(negedge clk);
        drive(z);
        rst = 1'b0;
        step(z, "post_rst_idle", 14'b0, 1, 14'b0, 0);
        step(i, "post_rst_start", 14'b1110001000_00_00, 1, 14'b0, 0);
        step(z, "drain", 14'b0, 0, 14'b0, 0);
        step(z, "drain", 14'b0, 0, 14'b0, 0);
        step(z, "drain", 14'b0, 0, 14'b0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            i.rs1d = 5'($urandom_range(0, 3)); i.rs2d = 5'($urandom_range(0, 3));
            i.rs1e = 5'($urandom_range(0, 3)); i.rs2e = 5'($urandom_range(0, 3));
            i.rde  = 5'($urandom_range(0, 3)); i.rdm  = 5'($urandom_range(0, 3));
            i.rdw  = 5'($urandom_range(0, 3)); i.rsrc = 2'($urandom_range(0, 3));
            i.start = ($urandom_range(0, 3) == 0); i.pcsrc = ($urandom_range(0, 3) == 0);
            i.rwm = 1'($urandom); i.rww = 1'($urandom);
            i.req = 1'($urandom); i.rdy = ($urandom_range(0, 2) != 0);
            step(i, $sformatf("rand%0d", n), ref_out(0, i), 1, ref_out(1, i), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
